// File: rtl/ram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_responder_pkg
// Description : Shared types and default constants for the RAM responder.
//               state_t      - responder FSM encoding (IDLE/BUSY/DONE)
//               RAM_*        - default word width, index width and latency
// Revision    : 1.0 - initial release
// ============================================================================
package ram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RAM_WORD_SIZE  = 32;
  localparam int RAM_INDEX_SIZE = 10;
  localparam int RAM_LATENCY    = 4;

endpackage : ram_responder_pkg
`default_nettype wire

// File: rtl/ram_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_mem_array
// Description : Word-wide storage array, synchronous write, combinational read.
//               One shared address serves both the write and the read port.
// Ports       : clk   in   rising-edge clock
//               we    in   write enable, sampled at posedge clk
//               addr  in   word index [index_size-1:0]
//               wdata in   write data [word_size-1:0]
//               rdata out  combinational read data of mem[addr]
// Revision    : 1.0 - initial release
// ============================================================================
module ram_mem_array #(
  parameter int word_size  = 32,
  parameter int index_size = 10,
  parameter int size       = 1024
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [index_size-1:0] addr,
  input  logic [word_size-1:0]  wdata,
  output logic [word_size-1:0]  rdata
);

  // Contents are intentionally never reset.
  logic [word_size-1:0] mem [size];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule : ram_mem_array
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_responder
// Description : Memory-side responder for the cache-to-RAM request interface.
//               A request is any change of data/addr/wr relative to the last
//               accepted one. After a fixed latency the access is performed and
//               response rises; it stays high until the next request.
// Ports       : clk      in   rising-edge clock
//               rst_n    in   asynchronous active-low reset
//               data     in   write data
//               addr     in   word address (low index_size bits used)
//               wr       in   1 = write, 0 = read
//               rd_cnt   out  completed-read count  (RAM_RESPONDER_STATS_EN)
//               wr_cnt   out  completed-write count (RAM_RESPONDER_STATS_EN)
//               response out  last accepted request complete
//               out      out  read data, or write data of a completed write
// Options     : define RAM_RESPONDER_STATS_EN to add saturating rd_cnt/wr_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int word_size  = RAM_WORD_SIZE,
  parameter int size       = 1024,
  parameter int index_size = RAM_INDEX_SIZE,
  parameter int latency    = RAM_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [word_size-1:0] data,
  input  logic [word_size-1:0] addr,
  input  logic                 wr,
`ifdef RAM_RESPONDER_STATS_EN
  output logic [31:0]          rd_cnt,
  output logic [31:0]          wr_cnt,
`endif
  output logic                 response,
  output logic [word_size-1:0] out
);

  localparam logic [7:0] c_lat_m1 = 8'(latency - 1);

  state_t               state_q,    state_d;
  logic [7:0]           counter_q,  counter_d;
  logic [word_size-1:0] data_q,     data_d;
  logic [word_size-1:0] addr_q,     addr_d;
  logic                 wr_q,       wr_d;
  logic                 response_q, response_d;
  logic [word_size-1:0] out_q,      out_d;

  logic                 new_req;
  logic                 complete;
  logic                 mem_we;
  logic [word_size-1:0] mem_rdata;

  ram_mem_array #(
    .word_size  (word_size),
    .index_size (index_size),
    .size       (size)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[index_size-1:0]),
    .wdata (data_q),
    .rdata (mem_rdata)
  );

  // Full-width compare: upper address bits still count as a new request even
  // though they alias in the array.
  assign new_req = (data != data_q) | (addr != addr_q) | (wr != wr_q);

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    data_d     = data_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    response_d = response_q;
    out_d      = out_q;
    mem_we     = 1'b0;
    complete   = 1'b0;

    // A new request always wins, including over a completion due this edge;
    // the in-flight access is simply dropped.
    if (new_req) begin
      data_d     = data;
      addr_d     = addr;
      wr_d       = wr;
      counter_d  = c_lat_m1;
      state_d    = BUSY;
      response_d = 1'b0;
    end else begin
      case (state_q)
        BUSY: begin
          if (counter_q != 8'd0) begin
            counter_d = counter_q - 8'd1;
          end else begin
            complete   = 1'b1;
            mem_we     = wr_q;
            out_d      = wr_q ? data_q : mem_rdata;
            response_d = 1'b1;
            state_d    = DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      counter_q  <= 8'd0;
      data_q     <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      response_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      response_q <= response_d;
      out_q      <= out_d;
    end
  end

  assign response = response_q;
  assign out      = out_q;

`ifdef RAM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (complete) begin
      if (wr_q && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_d = wr_cnt_q + 32'd1;
      if (!wr_q && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_d = rd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule : ram_responder
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_responder
// Description : Directed self-checking bench for ram_responder (default
//               parameters, latency 4). Define RAM_RESPONDER_STATS_EN to also
//               check the completion counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] addr = '0;
  logic        wr = 1'b0;
  logic        response;
  logic [31:0] out;
`ifdef RAM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .addr     (addr),
    .wr       (wr),
`ifdef RAM_RESPONDER_STATS_EN
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt),
`endif
    .response (response),
    .out      (out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] d, input logic [31:0] a, input logic w);
    data = d;
    addr = a;
    wr   = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Full transaction: inputs applied now, accepted at the next edge (T),
  // response low through T+3 and high with expected out at T+4.
  task automatic txn(input string tag, input logic [31:0] d, input logic [31:0] a,
                     input logic w, input logic [31:0] exp_out);
    issue(d, a, w);
    tick();
    chk({tag, "_resp_T"}, 32'(response), 32'd0);
    tick(); tick(); tick();
    chk({tag, "_resp_T3"}, 32'(response), 32'd0);
    tick();
    chk({tag, "_resp_T4"}, 32'(response), 32'd1);
    chk({tag, "_out_T4"}, out, exp_out);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_resp", 32'(response), 32'd0);
    chk("rst_out", out, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_resp", 32'(response), 32'd0);

    // Write then read back
    txn("wr5", 32'hDEADBEEF, 32'd5, 1'b1, 32'hDEADBEEF);
    txn("rd5", 32'hDEADBEEF, 32'd5, 1'b0, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_resp", 32'(response), 32'd1);
      chk("hold_out", out, 32'hDEADBEEF);
    end

    // Known content at addr 7 and addr 9 for later checks
    txn("wr7", 32'hCAFEF00D, 32'd7, 1'b1, 32'hCAFEF00D);
    txn("wr9", 32'hAAAA0009, 32'd9, 1'b1, 32'hAAAA0009);

    // Read of 5 abandoned at T+2 by a read of 7; response at T+6
    issue(32'h0, 32'd5, 1'b0);
    tick();
    chk("ab_rd_resp_T", 32'(response), 32'd0);
    tick();
    issue(32'h0, 32'd7, 1'b0);
    tick();
    tick(); tick(); tick();
    chk("ab_rd_resp_T5", 32'(response), 32'd0);
    tick();
    chk("ab_rd_resp_T6", 32'(response), 32'd1);
    chk("ab_rd_out", out, 32'hCAFEF00D);

    // Write to 5 abandoned at T+2 by a read of 5; memory must be unchanged
    issue(32'h11111111, 32'd5, 1'b1);
    tick();
    tick();
    issue(32'h11111111, 32'd5, 1'b0);
    tick();
    tick(); tick(); tick();
    chk("ab_wr_resp_T5", 32'(response), 32'd0);
    tick();
    chk("ab_wr_resp_T6", 32'(response), 32'd1);
    chk("ab_wr_out", out, 32'hDEADBEEF);

    // New request on the completion edge: the write to 9 is dropped
    issue(32'h22222222, 32'd9, 1'b1);
    tick();
    tick(); tick(); tick();
    issue(32'h22222222, 32'd9, 1'b0);
    tick();
    chk("prio_resp_T4", 32'(response), 32'd0);
    tick(); tick(); tick();
    chk("prio_resp_T7", 32'(response), 32'd0);
    tick();
    chk("prio_resp_T8", 32'(response), 32'd1);
    chk("prio_out", out, 32'hAAAA0009);

    // Asynchronous reset during BUSY aborts a write to 5
    issue(32'h55555555, 32'd5, 1'b1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_resp", 32'(response), 32'd0);
    chk("arst_out", out, 32'd0);
    tick();
    issue(32'h0, 32'd0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    txn("post_rst_rd5", 32'h0, 32'd5, 1'b0, 32'hDEADBEEF);

    // Aliasing: 0x405 and 0x005 hit the same word
    txn("wr405", 32'h12345678, 32'h405, 1'b1, 32'h12345678);
    txn("rd005", 32'h12345678, 32'h005, 1'b0, 32'h12345678);

`ifdef RAM_RESPONDER_STATS_EN
    // Since the last reset: reads of 5 and 0x005, one write of 0x405
    chk("stats_rd", rd_cnt, 32'd2);
    chk("stats_wr", wr_cnt, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_ram_responder
`default_nettype wire
